// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C master core among NREQ requesters.
// Tracks bus ownership across START/STOP and forces a STOP when an owner stalls or leaves the bus open.
module i2c_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 50000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   cmd_valid_i,
  input  logic [3*NREQ-1:0] cmd_i,
  input  logic [8*NREQ-1:0] wdata_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   cmd_ready_o,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic [7:0]        rdata_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              timeout_o,
  output logic [2:0]        core_cmd_o,
  output logic [7:0]        core_wdata_o,
  output logic              core_cmd_valid_o,
  input  logic              core_cmd_ready_i,
  input  logic              core_done_i,
  input  logic [7:0]        core_rdata_i,
  input  logic              core_ack_i
);

  localparam logic [2:0] CMD_START     = 3'd1;
  localparam logic [2:0] CMD_WRITE     = 3'd2;
  localparam logic [2:0] CMD_READ_ACK  = 3'd3;
  localparam logic [2:0] CMD_READ_NACK = 3'd4;
  localparam logic [2:0] CMD_STOP      = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_OWNED, ST_ISSUE, ST_WAIT, ST_FSTOP_ISSUE, ST_FSTOP_WAIT
  } state_t;

  state_t      state_r;
  logic [1:0]  owner_r;
  logic        bus_open_r;
  logic [15:0] cnt_r;

  logic        owner_req_s;
  logic        owner_valid_s;
  logic [2:0]  owner_cmd_s;
  logic [7:0]  owner_wdata_s;
  logic        found_s;
  logic [1:0]  pick_s;
  logic [1:0]  cand_s;

  function automatic logic bit_at(input logic [NREQ-1:0] v, input logic [1:0] k);
    logic [NREQ-1:0] s;
    s = v >> k;
    return s[0];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] k);
    logic [NREQ-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return one << k;
  endfunction

  function automatic logic legal_cmd(input logic [2:0] c);
    return (c >= CMD_START) && (c <= CMD_STOP);
  endfunction

  assign owner_req_s   = |(req_i & gnt_o);
  assign owner_valid_s = |(cmd_valid_i & gnt_o);
  assign owner_cmd_s   = 3'(cmd_i >> (3 * owner_r));
  assign owner_wdata_s = 8'(wdata_i >> (8 * owner_r));
  assign cmd_ready_o   = (state_r == ST_OWNED && owner_req_s) ? gnt_o : '0;

  // Round-robin search starting one past the most recent owner.
  always_comb begin
    found_s = 1'b0;
    pick_s  = owner_r;
    cand_s  = owner_r;
    for (int i = 1; i <= NREQ; i++) begin
      cand_s = 2'((int'(owner_r) + i) % NREQ);
      if (!found_s && bit_at(req_i, cand_s)) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Arbitration, command sequencing and response registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r          <= ST_IDLE;
      owner_r          <= 2'(NREQ - 1);
      bus_open_r       <= 1'b0;
      cnt_r            <= 16'd0;
      gnt_o            <= '0;
      rsp_valid_o      <= '0;
      rdata_o          <= 8'd0;
      ack_o            <= 1'b0;
      err_o            <= 1'b0;
      timeout_o        <= 1'b0;
      core_cmd_o       <= 3'd0;
      core_wdata_o     <= 8'd0;
      core_cmd_valid_o <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      timeout_o   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= 16'd0;
          if (found_s) begin
            owner_r <= pick_s;
            gnt_o   <= onehot(pick_s);
            state_r <= ST_OWNED;
          end else begin
            gnt_o <= '0;
          end
        end
        ST_OWNED: begin
          // A released request outranks any command presented in the same cycle.
          if (!owner_req_s) begin
            cnt_r <= 16'd0;
            if (bus_open_r) begin
              core_cmd_o       <= CMD_STOP;
              core_wdata_o     <= 8'd0;
              core_cmd_valid_o <= 1'b1;
              state_r          <= ST_FSTOP_ISSUE;
            end else begin
              gnt_o   <= '0;
              state_r <= ST_IDLE;
            end
          end else if (owner_valid_s) begin
            cnt_r <= 16'd0;
            if (legal_cmd(owner_cmd_s) && (bus_open_r || owner_cmd_s == CMD_START)) begin
              core_cmd_o       <= owner_cmd_s;
              core_wdata_o     <= owner_wdata_s;
              core_cmd_valid_o <= 1'b1;
              state_r          <= ST_ISSUE;
            end else begin
              rsp_valid_o <= gnt_o;
              err_o       <= 1'b1;
              ack_o       <= 1'b0;
            end
          end else if (cnt_r == 16'(TIMEOUT - 1) && bus_open_r) begin
            cnt_r            <= 16'd0;
            timeout_o        <= 1'b1;
            core_cmd_o       <= CMD_STOP;
            core_wdata_o     <= 8'd0;
            core_cmd_valid_o <= 1'b1;
            state_r          <= ST_FSTOP_ISSUE;
          end else if (cnt_r != 16'(TIMEOUT)) begin
            cnt_r <= cnt_r + 16'd1;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_ISSUE, ST_FSTOP_ISSUE: begin
          if (core_cmd_ready_i) begin
            core_cmd_valid_o <= 1'b0;
            state_r <= (state_r == ST_ISSUE) ? ST_WAIT : ST_FSTOP_WAIT;
          end else begin
            core_cmd_valid_o <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (core_done_i) begin
            rsp_valid_o <= gnt_o;
            err_o       <= 1'b0;
            if (core_cmd_o == CMD_READ_ACK || core_cmd_o == CMD_READ_NACK) begin
              rdata_o <= core_rdata_i;
            end else if (core_cmd_o == CMD_WRITE) begin
              ack_o <= core_ack_i;
            end else begin
              rdata_o <= rdata_o;
            end
            if (core_cmd_o == CMD_START) begin
              bus_open_r <= 1'b1;
              state_r    <= ST_OWNED;
            end else if (core_cmd_o == CMD_STOP) begin
              bus_open_r <= 1'b0;
              gnt_o      <= '0;
              state_r    <= ST_IDLE;
            end else begin
              state_r <= ST_OWNED;
            end
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_FSTOP_WAIT: begin
          if (core_done_i) begin
            bus_open_r <= 1'b0;
            gnt_o      <= '0;
            state_r    <= ST_IDLE;
          end else begin
            state_r <= ST_FSTOP_WAIT;
          end
        end
        default: begin
          state_r          <= ST_IDLE;
          gnt_o            <= '0;
          core_cmd_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of ownership and the core handshake.
module tb_i2c_arbiter;
  localparam int NREQ = 2;
  localparam int TO   = 8;
  localparam int M_FREE = 0, M_HELD = 1, M_SEND = 2, M_WAITD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]  req_i = '0, cmd_valid_i = '0;
  logic [5:0]  cmd_i = '0;
  logic [15:0] wdata_i = '0;
  logic [1:0]  gnt_o, cmd_ready_o, rsp_valid_o;
  logic [7:0]  rdata_o, core_wdata_o;
  logic        ack_o, err_o, timeout_o, core_cmd_valid_o;
  logic [2:0]  core_cmd_o;
  logic        core_cmd_ready_i = 1'b1, core_done_i = 1'b0, core_ack_i = 1'b1;
  logic [7:0]  core_rdata_i = '0;

  always #5 clk = ~clk;

  i2c_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req_i), .cmd_valid_i(cmd_valid_i),
    .cmd_i(cmd_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .cmd_ready_o(cmd_ready_o),
    .rsp_valid_o(rsp_valid_o), .rdata_o(rdata_o), .ack_o(ack_o), .err_o(err_o),
    .timeout_o(timeout_o), .core_cmd_o(core_cmd_o), .core_wdata_o(core_wdata_o),
    .core_cmd_valid_o(core_cmd_valid_o), .core_cmd_ready_i(core_cmd_ready_i),
    .core_done_i(core_done_i), .core_rdata_i(core_rdata_i), .core_ack_i(core_ack_i)
  );

  int n_chk = 0, n_pass = 0;
  int m_mode, m_own, m_idle, wait_cnt, done_dly;
  logic m_open, m_forced, rnd_core;
  logic [2:0] m_cmd, e_cmd;
  logic [1:0] e_gnt, e_rsp;
  logic [7:0] e_rdata, e_wd;
  logic e_ack, e_err, e_to, e_cv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic bitof(input logic [1:0] v, input int k);
    logic [1:0] s;
    s = v >> k;
    return s[0];
  endfunction

  function automatic logic [1:0] e_ready();
    if (m_mode == M_HELD && bitof(req_i, m_own)) return 2'b01 << m_own;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_mode = M_FREE; m_own = NREQ - 1; m_idle = 0; m_open = 1'b0; m_forced = 1'b0;
    m_cmd = 3'd0; e_gnt = '0; e_rsp = '0; e_rdata = 8'd0; e_ack = 1'b0; e_err = 1'b0;
    e_to = 1'b0; e_cv = 1'b0; e_cmd = 3'd0; e_wd = 8'd0; wait_cnt = 0; core_done_i = 1'b0;
  endtask

  task automatic start_stop();
    m_forced = 1'b1; m_cmd = 3'd5; e_cv = 1'b1; e_cmd = 3'd5; e_wd = 8'd0; m_mode = M_SEND;
  endtask

  // One clock of the reference: ownership rules applied to the inputs seen at the edge.
  task automatic model_step();
    logic [2:0] c;
    int k;
    e_rsp = '0; e_to = 1'b0;
    if (rst) begin model_reset(); return; end
    case (m_mode)
      M_FREE:
        for (int i = 1; i <= NREQ; i++) begin
          k = (m_own + i) % NREQ;
          if (bitof(req_i, k)) begin
            m_own = k; e_gnt = 2'b01 << k; m_mode = M_HELD; m_idle = 0;
            break;
          end
        end
      M_HELD: begin
        c = 3'(cmd_i >> (3 * m_own));
        if (!bitof(req_i, m_own)) begin
          m_idle = 0;
          if (m_open) start_stop();
          else begin e_gnt = '0; m_mode = M_FREE; end
        end else if (bitof(cmd_valid_i, m_own)) begin
          m_idle = 0;
          if (c >= 3'd1 && c <= 3'd5 && (m_open || c == 3'd1)) begin
            m_cmd = c; e_cv = 1'b1; e_cmd = c; e_wd = 8'(wdata_i >> (8 * m_own));
            m_mode = M_SEND;
          end else begin
            e_rsp = e_gnt; e_err = 1'b1; e_ack = 1'b0;
          end
        end else begin
          if (m_idle < TO) m_idle++;
          if (m_idle == TO && m_open) begin m_idle = 0; e_to = 1'b1; start_stop(); end
        end
      end
      M_SEND:
        if (core_cmd_ready_i) begin
          e_cv = 1'b0; m_mode = M_WAITD;
          wait_cnt = rnd_core ? int'($urandom_range(3, 1)) : done_dly;
        end
      M_WAITD:
        if (core_done_i) begin
          if (m_forced) begin
            m_forced = 1'b0; m_open = 1'b0; e_gnt = '0; m_mode = M_FREE;
          end else begin
            if (m_cmd == 3'd3 || m_cmd == 3'd4) e_rdata = core_rdata_i;
            if (m_cmd == 3'd2) e_ack = core_ack_i;
            e_err = 1'b0; e_rsp = e_gnt;
            if (m_cmd == 3'd1) m_open = 1'b1;
            if (m_cmd == 3'd5) begin m_open = 1'b0; e_gnt = '0; m_mode = M_FREE; end
            else m_mode = M_HELD;
          end
        end
      default: m_mode = M_FREE;
    endcase
  endtask

  task automatic drive_core();
    if (wait_cnt > 0) begin wait_cnt--; core_done_i = (wait_cnt == 0); end
    else core_done_i = 1'b0;
    if (rnd_core) begin
      core_cmd_ready_i = 1'($urandom); core_rdata_i = 8'($urandom); core_ack_i = 1'($urandom);
    end
  endtask

  // Advance one clock, then compare every output with the model away from the edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_step();
    check("outputs",
      {gnt_o, cmd_ready_o, rsp_valid_o, rdata_o, ack_o, err_o, timeout_o, core_cmd_valid_o, core_cmd_o, core_wdata_o},
      {e_gnt, e_ready(), e_rsp, e_rdata, e_ack, e_err, e_to, e_cv, e_cmd, e_wd});
    drive_core();
  endtask

  task automatic run_cmd(input int r, input logic [2:0] c, input logic [7:0] d);
    cmd_valid_i = 2'b01 << r;
    cmd_i = 6'(c) << (3 * r);
    wdata_i = 16'(d) << (8 * r);
    tick();
    cmd_valid_i = '0;
    for (int n = 0; n < 20 && rsp_valid_o == 2'b00; n++) tick();
  endtask

  function automatic logic [2:0] pick_cmd();
    case ($urandom_range(9, 0))
      0, 1:    return 3'd1;
      2, 3, 4: return 3'd2;
      5:       return 3'd3;
      6:       return 3'd4;
      7, 8:    return 3'd5;
      default: return 3'($urandom_range(7, 0));
    endcase
  endfunction

  initial begin
    int n;
    rnd_core = 1'b0; done_dly = 1;
    model_reset();
    tick(); tick();
    check("reset_outs", {gnt_o, cmd_ready_o, rsp_valid_o, rdata_o, ack_o, err_o, timeout_o,
                         core_cmd_valid_o, core_cmd_o, core_wdata_o}, 64'd0);
    rst = 1'b0;
    tick();
    req_i = 2'b11;
    tick();
    check("first_grant", gnt_o, 2'b01);

    run_cmd(0, 3'd1, 8'h00);
    check("start_rsp", {rsp_valid_o, err_o}, {2'b01, 1'b0});
    run_cmd(0, 3'd2, 8'hAE);
    check("write_rsp", {rsp_valid_o, ack_o, err_o, core_wdata_o}, {2'b01, 1'b1, 1'b0, 8'hAE});
    run_cmd(0, 3'd5, 8'h00);
    check("stop_rsp_gnt", {rsp_valid_o, gnt_o}, {2'b01, 2'b00});
    tick();
    check("second_grant", gnt_o, 2'b10);

    core_rdata_i = 8'h5A;
    run_cmd(1, 3'd1, 8'h00);
    run_cmd(1, 3'd4, 8'h00);
    check("read_nack", {rsp_valid_o, rdata_o, err_o}, {2'b10, 8'h5A, 1'b0});
    run_cmd(1, 3'd5, 8'h00);
    tick();
    check("fair_grant", gnt_o, 2'b01);

    run_cmd(0, 3'd2, 8'h11);
    check("write_closed", {rsp_valid_o, err_o, ack_o, core_cmd_valid_o}, {2'b01, 1'b1, 1'b0, 1'b0});
    run_cmd(0, 3'd0, 8'h00);
    check("cmd_zero", {rsp_valid_o, err_o, core_cmd_valid_o}, {2'b01, 1'b1, 1'b0});

    run_cmd(0, 3'd1, 8'h00);
    n = 0;
    while (timeout_o == 1'b0 && n < 20) begin tick(); n++; end
    check("timeout_cycles", 64'(n), 64'd8);
    check("timeout_stop", {timeout_o, core_cmd_valid_o, core_cmd_o}, {1'b1, 1'b1, 3'd5});
    n = 0;
    while (gnt_o != 2'b00 && n < 10) begin tick(); n++; end
    check("timeout_release", {gnt_o, rsp_valid_o}, {2'b00, 2'b00});
    tick();
    check("grant_after_to", gnt_o, 2'b10);

    done_dly = 4;
    cmd_valid_i = 2'b10; cmd_i = 6'b001_000;
    tick();
    cmd_valid_i = '0;
    tick();
    check("in_wait", {gnt_o, core_cmd_valid_o}, {2'b10, 1'b0});
    #2 rst = 1'b1;
    #1;
    check("async_reset", {gnt_o, cmd_ready_o, rsp_valid_o, rdata_o, ack_o, err_o, timeout_o,
                          core_cmd_valid_o, core_cmd_o, core_wdata_o}, 64'd0);
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    check("grant_after_rst", gnt_o, 2'b01);

    rnd_core = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic quiet;
      quiet = (cyc % 150) > 100;
      for (int r = 0; r < NREQ; r++) begin
        if (bitof(req_i, r)) begin
          if ($urandom_range(24, 0) == 0) req_i = req_i & ~(2'b01 << r);
        end else if ($urandom_range(3, 0) == 0) begin
          req_i = req_i | (2'b01 << r);
        end
        if (!quiet && $urandom_range(2, 0) == 0) cmd_valid_i = cmd_valid_i | (2'b01 << r);
        else cmd_valid_i = cmd_valid_i & ~(2'b01 << r);
      end
      cmd_i = {pick_cmd(), pick_cmd()};
      wdata_i = 16'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
